// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-lane word array with optional wait states.
// Ports: clk/rst, data_sram_{en,wen,addr,wdata} in; data_sram_rdata, stallreq, addr_err out.
module data_sram_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic        acc_go;
  logic [31:0] acc_addr;
  logic [3:0]  acc_wen;
  logic [31:0] acc_wdata;
  logic [31:0] off;
  logic        in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic        wr_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    stallreq  = 1'b0;
    acc_go    = 1'b0;
    acc_addr  = addr_q;
    acc_wen   = wen_q;
    acc_wdata = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (data_sram_en) begin
          if (WAIT_CYCLES == 0) begin
            acc_go    = 1'b1;
            acc_addr  = data_sram_addr;
            acc_wen   = data_sram_wen;
            acc_wdata = data_sram_wdata;
          end else begin
            stallreq = 1'b1;
            addr_d   = data_sram_addr;
            wen_d    = data_sram_wen;
            wdata_d  = data_sram_wdata;
            // Counter holds the number of WAIT cycles still to spend.
            cnt_d    = 4'(WAIT_CYCLES - 1);
            state_d  = (WAIT_CYCLES >= 2) ? S_WAIT : S_DONE;
          end
        end
      end
      S_WAIT: begin
        stallreq = 1'b1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        acc_go  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Offset is only meaningful when addr >= BASE_ADDR; the 33-bit span
  // compare keeps the upper bound exact without wrap.
  assign off      = acc_addr - BASE_ADDR;
  assign in_range = (acc_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign idx      = off[ADDR_WIDTH+1:2];
  assign wr_en    = acc_go && in_range && (|acc_wen) && !rst;

  logic unused_bits;
  assign unused_bits = ^{off[1:0], off[31:ADDR_WIDTH+2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wen_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      err_q   <= acc_go && !in_range;
      if (acc_go)
        rdata_q <= in_range ? mem_q[idx] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i])
          mem_q[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign addr_err        = err_q;

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Memory-side responder for the pipeline's data-SRAM port: accepts the enable/byte-write-enable/address/write-data request driven from EX, performs the read or byte-lane write on an internal word array, and returns the raw 32-bit word on `data_sram_rdata` for the MEM stage's lane extraction and sign handling. A parameterised wait-state counter emulates slow memory by raising `stallreq` to the stall controller, so MEM/WB forwarding and stall paths can be exercised without an external bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: word-index bits; array depth = 2^ADDR_WIDTH words.
- `WAIT_CYCLES`, 0: extra wait states per access, legal 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_wen`  in  4  byte-lane write enables; bit i writes `wdata[8i+7:8i]`; 4'b0000 = read.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  lane-aligned store data.
- `data_sram_rdata`  out  32  registered word read from the array.
- `stallreq`  out  1  high while a wait-state access is pending; to stall controller.
- `addr_err`  out  1  one-cycle pulse: completed access was out of range.

## Operation
- Word index = (addr − BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits. In range iff BASE_ADDR ≤ addr < BASE_ADDR + 4·2^ADDR_WIDTH (32-bit unsigned compare, no wrap).
- FSM states: IDLE, WAIT, DONE.
  - IDLE, en=0: no action; `rdata` holds.
  - IDLE, en=1, WAIT_CYCLES=0: access performed at the edge ending the request cycle; stay IDLE.
  - IDLE, en=1, WAIT_CYCLES=W>0: latch addr/wen/wdata; load down-counter; go to WAIT (W≥2) or DONE (W=1).
  - WAIT: counter decrements; go to DONE on the last wait cycle.
  - DONE: perform the latched access; return to IDLE; request inputs this cycle are not a new request.
- Read (wen=0): `rdata` ← array[index].
- Write (wen≠0): enabled lanes updated; disabled lanes unchanged. `rdata` ← pre-write word (read-before-write).
- Out of range: array not modified; `rdata` ← 32'h0; `addr_err` = 1 in the cycle `rdata` updates.
- No lane extraction, sign extension or alignment check is done here. Those belong to the requester.
- Array contents are not reset and are undefined until written.

## Timing
- Reset: `data_sram_rdata`=0, `stallreq`=0, `addr_err`=0, state IDLE, counter 0. This takes effect on the first edge with rst=1.
- Reset mid-WAIT/DONE: pending access is abandoned. A latched write is never committed.
- WAIT_CYCLES=0: request in cycle N → `rdata` valid in cycle N+1 and held until the next completed access. `stallreq` is constant 0. Back-to-back requests are accepted every cycle.
- WAIT_CYCLES=W>0, request in cycle N:
  - `stallreq`=1 in cycles N..N+W−1. It is combinational in cycle N (en in IDLE) and registered state thereafter.
  - Cycle N+W is DONE with `stallreq`=0.
  - Array access occurs at the edge ending cycle N+W.
  - `rdata` / `addr_err` update in cycle N+W+1.
  - The next request is accepted from cycle N+W+1.
  - Inputs in N+1..N+W are ignored. The requester holds them stable by stalling.
- Read-after-write to the same word in consecutive requests returns the written data.
- Same-cycle read/write does not occur because there is a single port.
- `addr_err` is high for exactly one cycle per out-of-range access and is never held.

## Test plan
- Reset then idle, W=0: after rst, `rdata`=0, `stallreq`=0, `addr_err`=0. With en low for 5 cycles, all outputs stay 0.
- Byte-lane write/read, W=0: write 32'h1122_3344 wen=4'hF at 0x10, then 32'hAABB_CCDD wen=4'b0101 at 0x10, then read 0x10.
  - Second write's `rdata` = 32'h1122_3344 (pre-write).
  - Final read gives 32'h11BB_33DD in the cycle after the request.
- Back-to-back, W=0: write 0x20←32'hDEAD_BEEF in cycle N, read 0x20 in N+1 → `rdata`=32'hDEAD_BEEF in N+2. `stallreq` stays 0 throughout.
- Wait states, W=3: read of 0x04 (preloaded 32'h0000_00FF) in cycle N.
  - `stallreq`=1 in N..N+2 and 0 in N+3.
  - `rdata`=32'h0000_00FF in N+4.
  - A changed addr during N+1..N+3 has no effect.
- Out of range, BASE_ADDR=0x1000, ADDR_WIDTH=4: write 0x0FFC and 0x1040, then read 0x1040.
  - Array unchanged (read of 0x1000 returns prior value).
  - Each access gives `addr_err` 1-cycle pulse and `rdata`=0.
- Reset mid-operation, W=4: write 0x08←32'h5555_5555 in cycle N, assert rst in N+2.
  - `stallreq`=0 the cycle after reset.
  - A later read of 0x08 returns the old contents, not 32'h5555_5555.
